// File: rtl/pred_ctx_seq.sv
// Context sequencer for the per-PE predicate register file.
// Holds a small memory of predicate-control words loaded over a valid/ready
// port and replays words 0..len-1 for a number of iterations once started.
// All control outputs come straight from registers, so they are stable across
// the negedge where the predicate file writes.
module pred_ctx_seq #(
    parameter int unsigned CTX_DEPTH = 16,
    parameter int unsigned AW        = 4,
    parameter int unsigned CW        = 48,
    parameter int unsigned ITW       = 16
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           cfg_valid,
    output logic           cfg_ready,
    input  logic [AW-1:0]  cfg_addr,
    input  logic [CW-1:0]  cfg_data,
    input  logic           start,
    input  logic [AW:0]    ctx_len,
    input  logic [ITW-1:0] iter_cnt,
    input  logic           stall,
    input  logic           abort,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic [AW-1:0]  pc,
    output logic           write_back_p,
    output logic [8:0]     control_in_p,
    output logic [5:0]     control_put_in_p,
    output logic [5:0]     control_put_out_p,
    output logic [5:0]     control_pred,
    output logic [5:0]     control_send_p,
    output logic [8:0]     control_out_p,
    output logic [3:0]     control_pe2fu_p
);

    // NOP: puts target the scratch slot 63, pe2fu all-ones makes pred_out read 0.
    localparam logic [CW-1:0] NopWord =
        CW'({1'b0, 1'b0, 9'd0, 6'd63, 6'd63, 6'd0, 6'd0, 9'd0, 4'hF});
    localparam logic [AW:0] MaxLen = (AW+1)'(CTX_DEPTH);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e         state_q, state_d;
    logic [AW-1:0]  pc_q, pc_d;
    logic [AW:0]    len_q, len_d;
    logic [ITW-1:0] iter_q, iter_d;
    logic [CW-1:0]  word_q, word_d;
    logic           hold_q, hold_d;
    logic           done_q, done_d;
    logic           err_q, err_d;

    logic [CW-1:0]  mem [CTX_DEPTH];

    logic           cfg_we;
    logic           start_ok;
    logic           last_word;
    logic [AW-1:0]  pc_next;
    logic [CW-1:0]  word0;

    assign cfg_we    = cfg_valid && (state_q == StIdle);
    assign start_ok  = (ctx_len != '0) && (ctx_len <= MaxLen) && (iter_cnt != '0);
    assign last_word = ({1'b0, pc_q} == (len_q - (AW+1)'(1)));
    assign pc_next   = last_word ? '0 : pc_q + AW'(1);
    // A write to word 0 in the start cycle must be visible to the first replayed word.
    assign word0     = (cfg_we && (cfg_addr == '0)) ? cfg_data : mem[0];

    // Context memory: written only in IDLE, never reset.
    always_ff @(posedge CLK) begin
        if (cfg_we) begin
            mem[cfg_addr] <= cfg_data;
        end
    end

    // State and output registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StIdle;
            pc_q    <= '0;
            len_q   <= '0;
            iter_q  <= '0;
            word_q  <= NopWord;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            len_q   <= len_d;
            iter_q  <= iter_d;
            word_q  <= word_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next-state: launch checks in IDLE, sequencing/stall/abort in RUN.
    // hold_q marks a word at pc_q that was parked by stall and not yet emitted,
    // so a stall never causes the same word to be written twice.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        len_d   = len_q;
        iter_d  = iter_q;
        word_d  = word_q;
        hold_d  = hold_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                word_d = NopWord;
                pc_d   = '0;
                hold_d = 1'b0;
                if (start) begin
                    if (start_ok) begin
                        state_d = StRun;
                        len_d   = ctx_len;
                        iter_d  = iter_cnt;
                        word_d  = word0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StRun: begin
                if (abort) begin
                    state_d = StIdle;
                    word_d  = NopWord;
                    pc_d    = '0;
                    hold_d  = 1'b0;
                end else if (hold_q) begin
                    if (stall) begin
                        word_d = NopWord;
                    end else begin
                        word_d = mem[pc_q];
                        hold_d = 1'b0;
                    end
                end else if (last_word && (iter_q == ITW'(1))) begin
                    state_d = StIdle;
                    word_d  = NopWord;
                    pc_d    = '0;
                    done_d  = 1'b1;
                end else begin
                    pc_d = pc_next;
                    if (last_word) begin
                        iter_d = iter_q - ITW'(1);
                    end
                    if (stall) begin
                        word_d = NopWord;
                        hold_d = 1'b1;
                    end else begin
                        word_d = mem[pc_next];
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign cfg_ready         = (state_q == StIdle);
    assign busy              = (state_q == StRun);
    assign done              = done_q;
    assign err               = err_q;
    assign pc                = pc_q;
    assign write_back_p      = word_q[46];
    assign control_in_p      = word_q[45:37];
    assign control_put_in_p  = word_q[36:31];
    assign control_put_out_p = word_q[30:25];
    assign control_pred      = word_q[24:19];
    assign control_send_p    = word_q[18:13];
    assign control_out_p     = word_q[12:4];
    assign control_pe2fu_p   = word_q[3:0];

    // Bit 47 is a spare field in the word format.
    logic unused_spare;
    assign unused_spare = word_q[CW-1];

endmodule

// File: tb/tb_pred_ctx_seq.sv
// Directed bench for pred_ctx_seq: replay, stall, rejected starts, config
// blocking during a run, async reset, abort and single-word contexts.
module tb_pred_ctx_seq;

    logic        CLK = 1'b0;
    logic        RST;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [3:0]  cfg_addr;
    logic [47:0] cfg_data;
    logic        start;
    logic [4:0]  ctx_len;
    logic [15:0] iter_cnt;
    logic        stall;
    logic        abort;
    logic        busy;
    logic        done;
    logic        err;
    logic [3:0]  pc;
    logic        write_back_p;
    logic [8:0]  control_in_p;
    logic [5:0]  control_put_in_p;
    logic [5:0]  control_put_out_p;
    logic [5:0]  control_pred;
    logic [5:0]  control_send_p;
    logic [8:0]  control_out_p;
    logic [3:0]  control_pe2fu_p;

    int n_cmp = 0;
    int n_bad = 0;

    logic [47:0] nop_word;
    logic [47:0] wd;
    logic [47:0] word_tab [3];
    logic [4:0]  bad_len [3];
    logic [15:0] bad_it [3];

    pred_ctx_seq dut (
        .CLK               (CLK),
        .RST               (RST),
        .cfg_valid         (cfg_valid),
        .cfg_ready         (cfg_ready),
        .cfg_addr          (cfg_addr),
        .cfg_data          (cfg_data),
        .start             (start),
        .ctx_len           (ctx_len),
        .iter_cnt          (iter_cnt),
        .stall             (stall),
        .abort             (abort),
        .busy              (busy),
        .done              (done),
        .err               (err),
        .pc                (pc),
        .write_back_p      (write_back_p),
        .control_in_p      (control_in_p),
        .control_put_in_p  (control_put_in_p),
        .control_put_out_p (control_put_out_p),
        .control_pred      (control_pred),
        .control_send_p    (control_send_p),
        .control_out_p     (control_out_p),
        .control_pe2fu_p   (control_pe2fu_p)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    // Observed status + control fields, packed in word-bit order.
    function automatic logic [63:0] obs();
        return {10'b0, busy, done, err, pc, write_back_p, control_in_p, control_put_in_p,
                control_put_out_p, control_pred, control_send_p, control_out_p,
                control_pe2fu_p};
    endfunction

    function automatic logic [63:0] expv(input logic b, input logic d, input logic e,
                                         input logic [3:0] p, input logic [47:0] w);
        return {10'b0, b, d, e, p, w[46:0]};
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [47:0] d);
        cfg_valid = 1'b1;
        cfg_addr  = a;
        cfg_data  = d;
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic launch(input logic [4:0] len, input logic [15:0] it);
        start    = 1'b1;
        ctx_len  = len;
        iter_cnt = it;
        step();
        start    = 1'b0;
    endtask

    initial begin
        nop_word    = {1'b0, 1'b0, 9'd0, 6'd63, 6'd63, 6'd0, 6'd0, 9'd0, 4'hF};
        word_tab[0] = 48'h8123_4567_89AB;  // spare bit set, must not appear
        word_tab[1] = 48'h7EDC_BA98_7654;
        word_tab[2] = 48'h0F0F_F0F0_A5A5;
        wd          = 48'h1357_9BDF_2468;
        bad_len[0] = 5'd0;  bad_it[0] = 16'd1;
        bad_len[1] = 5'd17; bad_it[1] = 16'd1;
        bad_len[2] = 5'd3;  bad_it[2] = 16'd0;
        RST = 1'b0; cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0; start = 1'b0;
        ctx_len = '0; iter_cnt = '0; stall = 1'b0; abort = 1'b0;

        #2 RST = 1'b1;
        #2;
        check("rst_state", obs(), expv(0, 0, 0, 4'd0, nop_word));
        check("rst_ready", {63'b0, cfg_ready}, 64'd1);
        #8 RST = 1'b0;

        cfg_write(4'd0, word_tab[0]);
        cfg_write(4'd1, word_tab[1]);
        cfg_write(4'd2, word_tab[2]);

        // Basic replay: 3 words, 2 iterations.
        launch(5'd3, 16'd2);
        for (int i = 0; i < 6; i++) begin
            if (i != 0) step();
            check("run_word", obs(), expv(1, 0, 0, 4'(i % 3), word_tab[i % 3]));
        end
        step();
        check("run_done", obs(), expv(0, 1, 0, 4'd0, nop_word));
        step();
        check("run_idle", obs(), expv(0, 0, 0, 4'd0, nop_word));

        // Stall for 3 cycles at pc=1.
        launch(5'd3, 16'd1);
        check("stall_a", obs(), expv(1, 0, 0, 4'd0, word_tab[0]));
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("stall_nop", obs(), expv(1, 0, 0, 4'd1, nop_word));
        end
        stall = 1'b0;
        step();
        check("stall_b", obs(), expv(1, 0, 0, 4'd1, word_tab[1]));
        step();
        check("stall_c", obs(), expv(1, 0, 0, 4'd2, word_tab[2]));
        step();
        check("stall_done", obs(), expv(0, 1, 0, 4'd0, nop_word));

        // Rejected starts.
        step();
        for (int e = 0; e < 3; e++) begin
            launch(bad_len[e], bad_it[e]);
            check("err_pulse", obs(), expv(0, 0, 1, 4'd0, nop_word));
            step();
            check("err_clear", obs(), expv(0, 0, 0, 4'd0, nop_word));
        end

        // Config write attempted during a run must be refused.
        launch(5'd3, 16'd1);
        cfg_valid = 1'b1;
        cfg_addr  = 4'd1;
        cfg_data  = wd;
        check("run_ready", {63'b0, cfg_ready}, 64'd0);
        check("cfg_run_a", obs(), expv(1, 0, 0, 4'd0, word_tab[0]));
        step();
        check("cfg_run_b", obs(), expv(1, 0, 0, 4'd1, word_tab[1]));
        step();
        check("cfg_run_c", obs(), expv(1, 0, 0, 4'd2, word_tab[2]));
        step();
        cfg_valid = 1'b0;
        check("cfg_run_done", obs(), expv(0, 1, 0, 4'd0, nop_word));

        // Asynchronous reset mid-run at pc=2.
        launch(5'd3, 16'd2);
        step();
        step();
        check("pre_rst_c", obs(), expv(1, 0, 0, 4'd2, word_tab[2]));
        #3 RST = 1'b1;
        #1;
        check("rst_async", obs(), expv(0, 0, 0, 4'd0, nop_word));
        #2 RST = 1'b0;
        step();

        // Memory survives reset and the refused write.
        launch(5'd3, 16'd1);
        for (int i = 0; i < 3; i++) begin
            if (i != 0) step();
            check("mem_keep", obs(), expv(1, 0, 0, 4'(i), word_tab[i]));
        end
        step();
        check("mem_keep_done", obs(), expv(0, 1, 0, 4'd0, nop_word));

        // Abort at pc=1 of the second iteration.
        launch(5'd3, 16'd2);
        for (int i = 1; i < 5; i++) step();
        check("pre_abort_b", obs(), expv(1, 0, 0, 4'd1, word_tab[1]));
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_nop", obs(), expv(0, 0, 0, 4'd0, nop_word));
        step();
        check("abort_no_done", obs(), expv(0, 0, 0, 4'd0, nop_word));

        // ctx_len=1 with a simultaneous write to word 0.
        cfg_valid = 1'b1;
        cfg_addr  = 4'd0;
        cfg_data  = wd;
        launch(5'd1, 16'd2);
        cfg_valid = 1'b0;
        check("len1_w0", obs(), expv(1, 0, 0, 4'd0, wd));
        step();
        check("len1_w1", obs(), expv(1, 0, 0, 4'd0, wd));
        step();
        check("len1_done", obs(), expv(0, 1, 0, 4'd0, nop_word));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
